gmii_rx_checker: RTL and testbench
==================================

// Module: gmii_rx_checker
// PURPOSE
//  GMII receive-side frame checker; counterpart of the bench GMII frame generator.
//  Strips preamble/SFD, captures dst/src MAC and type/length, checks FCS and length.
//  Reports per-frame status plus saturating counters.
//  Sits on each HSR node RX tap in the bench; synthesizable for on-FPGA loopback.
// PARAMETERS
//  MIN_FRAME   64    min bytes dst-MAC..FCS inclusive; shorter = runt
//  MAX_FRAME   1522  max bytes dst-MAC..FCS inclusive; longer = oversize
//  CNT_WIDTH   16    width of each status counter (saturating)
//  PROMISC     0     1: accept any dst MAC; 0: unicast==mac_addr or broadcast only
// PORTS
//  gmii_rxc     in   1          receive clock, 125MHz; all logic on rising edge
//  reset        in   1          asynchronous, active-high reset
//  gmii_rxd     in   8          receive data
//  gmii_rxdv    in   1          receive data valid
//  gmii_rxer    in   1          receive error
//  mac_addr     in   48         own MAC for address filter; quasi-static
//  rx_done      out  1          1-cycle pulse: frame ended, status below valid
//  rx_ok        out  1          frame good: FCS ok, length ok, no rxer, addr match
//  rx_crc_err   out  1          FCS residue mismatch
//  rx_len_err   out  1          runt or oversize
//  rx_phy_err   out  1          gmii_rxer seen inside frame
//  rx_addr_hit  out  1          dst MAC accepted by filter
//  rx_dst_mac   out  48         captured dst MAC (first byte = [47:40])
//  rx_src_mac   out  48         captured src MAC
//  rx_eth_type  out  16         captured type/length (first byte = [15:8])
//  rx_bnum      out  16         bytes dst-MAC..FCS, saturates at MAX_FRAME+1
//  cnt_good     out  CNT_WIDTH  frames with rx_ok
//  cnt_crc      out  CNT_WIDTH  frames with rx_crc_err
//  cnt_len      out  CNT_WIDTH  frames with rx_len_err
//  cnt_phy      out  CNT_WIDTH  frames with rx_phy_err
// BEHAVIOUR
//  Reset: every output 0; FSM IDLE; CRC reg 32'hFFFF_FFFF. Reset mid-frame aborts; no rx_done.
//  FSM: IDLE -> PRE on rxdv=1 & rxd=8'h55; IDLE stays if rxdv=1 & other byte (DROP).
//   PRE: 8'h55 stay (max 7 total, 8th 55 -> DROP); 8'hD5 -> BODY; other -> DROP; rxdv=0 -> IDLE.
//   BODY: per rxdv=1 byte: bnum++, CRC update, header capture at bnum 0..13.
//   BODY rxdv=0 -> END; END: rx_done=1 for exactly one cycle, counters update, -> IDLE.
//   DROP: wait rxdv=0 -> IDLE; no rx_done, no counter change.
//  PRE aborted by rxdv=0: silent, no rx_done.
//  CRC: IEEE 802.3, reflected, poly 32'hEDB88320, LSB-first, init all-ones, byte/cycle over
//   dst..FCS inclusive; good iff final register == 32'hDEBB20E3. No inversion stored.
//  Length: len_err iff bnum<MIN_FRAME or bnum>MAX_FRAME. bnum stops at MAX_FRAME+1 (no wrap);
//   CRC keeps running past MAX_FRAME.
//  bnum<14: unreceived header bytes read 0; addr_hit evaluated on whatever was captured.
//  rxer while rxdv=1 in PRE/BODY sets phy_err sticky for that frame; in PRE frame continues.
//  Status outputs held from rx_done until the next rx_done (not cleared in between).
//  Latency: rx_done in 2nd cycle after last rxdv=1 byte (1 cycle END after rxdv drop).
//  rx_ok = !crc_err & !len_err & !phy_err & addr_hit.
//  Counter increments independent (frame may bump cnt_crc and cnt_len); all saturate at all-ones.
//  Back-to-back: rxdv re-asserts in END cycle -> evaluated in IDLE next cycle; min IFG 1.
// CONFIGURATION
//  GMII_RX_PAYLOAD_CHECK_EN defined: payload byte k (bytes 14..bnum-5, k from 0) must equal
//   (k+1) mod 256; mismatch sets extra output rx_pay_err (1 bit, reset 0, held like status)
//   and forces rx_ok=0; cnt_good not incremented.
//  Undefined: no payload compare logic, no rx_pay_err port; rx_ok as above.
// TESTING
//  1 mac_addr=48'h02_12_34_56_78_01; 7x55,D5, 64B unicast frame dst=mac_addr, good FCS
//    -> rx_done once, rx_ok=1, rx_bnum=64, rx_eth_type=16'd46, cnt_good=1.
//  2 same frame, payload byte 20 bit flipped -> rx_crc_err=1, rx_ok=0, cnt_crc=1, cnt_good unchanged.
//  3 60B frame good FCS -> rx_len_err=1, cnt_len=1; 1600B frame -> rx_bnum=1523, cnt_len=2.
//  4 gmii_rxer=1 one cycle mid-payload -> rx_phy_err=1, cnt_phy=1; dst=FF..FF -> rx_addr_hit=1;
//    dst=02_12_34_56_78_02 (PROMISC=0) -> rx_addr_hit=0, rx_ok=0.
//  5 preamble 55,55,AA,... -> no rx_done, counters unchanged; reset asserted mid-BODY ->
//    outputs 0, next good frame gives cnt_good=1.
//  6 two good frames IFG=1 -> two rx_done pulses, cnt_good=2; with GMII_RX_PAYLOAD_CHECK_EN,
//    payload 1,2,..,46 -> rx_pay_err=0; payload byte 5=8'h00 (FCS fixed) -> rx_pay_err=1.

Source files
------------

// File: rtl/gmii_rx_checker.sv
// gmii_rx_checker: GMII receive frame checker.
// Strips preamble/SFD, captures the Ethernet header, checks the FCS residue,
// frame length, PHY errors and destination address, then reports one status
// pulse per frame and keeps saturating per-class frame counters.
// Optional build macro GMII_RX_PAYLOAD_CHECK_EN adds a payload pattern check
// (payload byte k must equal (k+1) mod 256) and the rx_pay_err output.
module gmii_rx_checker #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1522,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned PROMISC   = 0
) (
  input  logic                 gmii_rxc,
  input  logic                 reset,
  input  logic [7:0]           gmii_rxd,
  input  logic                 gmii_rxdv,
  input  logic                 gmii_rxer,
  input  logic [47:0]          mac_addr,
  output logic                 rx_done,
  output logic                 rx_ok,
  output logic                 rx_crc_err,
  output logic                 rx_len_err,
  output logic                 rx_phy_err,
  output logic                 rx_addr_hit,
  output logic [47:0]          rx_dst_mac,
  output logic [47:0]          rx_src_mac,
  output logic [15:0]          rx_eth_type,
  output logic [15:0]          rx_bnum,
`ifdef GMII_RX_PAYLOAD_CHECK_EN
  output logic                 rx_pay_err,
`endif
  output logic [CNT_WIDTH-1:0] cnt_good,
  output logic [CNT_WIDTH-1:0] cnt_crc,
  output logic [CNT_WIDTH-1:0] cnt_len,
  output logic [CNT_WIDTH-1:0] cnt_phy
);

  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESID = 32'hDEBB_20E3;
  localparam logic [15:0] BNUM_SAT  = 16'(MAX_FRAME + 1);
  localparam logic [15:0] BNUM_MIN  = 16'(MIN_FRAME);
  localparam logic [15:0] BNUM_MAX  = 16'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_BODY,
    S_END,
    S_DROP
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  pre_cnt;
  logic [31:0] crc;
  logic [15:0] bnum;
  logic [47:0] dst_cap;
  logic [47:0] src_cap;
  logic [15:0] type_cap;
  logic        phy_acc;

  logic        frame_open;
  logic        frame_start;
  logic        byte_in;
  logic        frame_end;
  logic        crc_bad;
  logic        len_bad;
  logic        addr_hit;
  logic        pay_bad;
  logic        frame_ok;

  // reflected CRC-32, one byte per call, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // frame state register
  always_ff @(posedge gmii_rxc or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // next-state decode and per-cycle strobes
  always_comb begin
    state_nx    = state;
    frame_open  = 1'b0;
    frame_start = 1'b0;
    byte_in     = 1'b0;
    frame_end   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gmii_rxdv) begin
          if (gmii_rxd == PRE_BYTE) begin
            state_nx   = S_PRE;
            frame_open = 1'b1;
          end else begin
            state_nx = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!gmii_rxdv) begin
          state_nx = S_IDLE;
        end else if (gmii_rxd == PRE_BYTE) begin
          if (pre_cnt == 3'd7) state_nx = S_DROP;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_nx    = S_BODY;
          frame_start = 1'b1;
        end else begin
          state_nx = S_DROP;
        end
      end
      S_BODY: begin
        if (gmii_rxdv) begin
          byte_in = 1'b1;
        end else begin
          state_nx  = S_END;
          frame_end = 1'b1;
        end
      end
      S_END: begin
        state_nx = S_IDLE;
      end
      S_DROP: begin
        if (!gmii_rxdv) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // preamble length, PHY error accumulation, CRC, byte count and header capture
  always_ff @(posedge gmii_rxc or posedge reset) begin
    if (reset) begin
      pre_cnt  <= '0;
      phy_acc  <= 1'b0;
      crc      <= CRC_INIT;
      bnum     <= '0;
      dst_cap  <= '0;
      src_cap  <= '0;
      type_cap <= '0;
    end else begin
      if (frame_open) begin
        pre_cnt <= 3'd1;
        phy_acc <= gmii_rxer;
      end else if (state == S_PRE && gmii_rxdv) begin
        if (gmii_rxd == PRE_BYTE && pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
        if (gmii_rxer) phy_acc <= 1'b1;
      end else if (byte_in && gmii_rxer) begin
        phy_acc <= 1'b1;
      end

      if (frame_start) begin
        crc      <= CRC_INIT;
        bnum     <= '0;
        dst_cap  <= '0;
        src_cap  <= '0;
        type_cap <= '0;
      end else if (byte_in) begin
        crc <= crc_byte(crc, gmii_rxd);
        if (bnum != BNUM_SAT) bnum <= bnum + 16'd1;
        for (int unsigned i = 0; i < 6; i++) begin
          if (bnum == 16'(i))     dst_cap[47-8*i -: 8] <= gmii_rxd;
          if (bnum == 16'(i + 6)) src_cap[47-8*i -: 8] <= gmii_rxd;
        end
        if (bnum == 16'd12) type_cap[15:8] <= gmii_rxd;
        if (bnum == 16'd13) type_cap[7:0]  <= gmii_rxd;
      end
    end
  end

`ifdef GMII_RX_PAYLOAD_CHECK_EN
  logic [7:0] idx8;
  logic [3:0] mis_pipe;
  logic       pay_acc;
  logic       mis_now;

  // the last four bytes may turn out to be FCS, so a byte's mismatch only
  // counts once four more bytes have arrived behind it
  always_comb begin
    mis_now = (bnum >= 16'd14) && (gmii_rxd != (idx8 - 8'd13));
  end

  // payload pattern tracking with a four-byte confirmation delay
  always_ff @(posedge gmii_rxc or posedge reset) begin
    if (reset) begin
      idx8     <= '0;
      mis_pipe <= '0;
      pay_acc  <= 1'b0;
    end else if (frame_start) begin
      idx8     <= '0;
      mis_pipe <= '0;
      pay_acc  <= 1'b0;
    end else if (byte_in) begin
      idx8     <= idx8 + 8'd1;
      mis_pipe <= {mis_pipe[2:0], mis_now};
      pay_acc  <= pay_acc | mis_pipe[3];
    end
  end

  // payload error status held between frame reports
  always_ff @(posedge gmii_rxc or posedge reset) begin
    if (reset)          rx_pay_err <= 1'b0;
    else if (frame_end) rx_pay_err <= pay_acc;
  end

  assign pay_bad = pay_acc;
`else
  assign pay_bad = 1'b0;
`endif

  // end-of-frame verdicts from the accumulated frame state
  always_comb begin
    crc_bad  = (crc != CRC_RESID);
    len_bad  = (bnum < BNUM_MIN) || (bnum > BNUM_MAX);
    addr_hit = (PROMISC != 0) || (dst_cap == mac_addr) || (dst_cap == '1);
    frame_ok = !crc_bad && !len_bad && !phy_acc && addr_hit && !pay_bad;
  end

  // status latch and done pulse; status holds until the next frame report
  always_ff @(posedge gmii_rxc or posedge reset) begin
    if (reset) begin
      rx_done     <= 1'b0;
      rx_ok       <= 1'b0;
      rx_crc_err  <= 1'b0;
      rx_len_err  <= 1'b0;
      rx_phy_err  <= 1'b0;
      rx_addr_hit <= 1'b0;
      rx_dst_mac  <= '0;
      rx_src_mac  <= '0;
      rx_eth_type <= '0;
      rx_bnum     <= '0;
    end else begin
      rx_done <= frame_end;
      if (frame_end) begin
        rx_ok       <= frame_ok;
        rx_crc_err  <= crc_bad;
        rx_len_err  <= len_bad;
        rx_phy_err  <= phy_acc;
        rx_addr_hit <= addr_hit;
        rx_dst_mac  <= dst_cap;
        rx_src_mac  <= src_cap;
        rx_eth_type <= type_cap;
        rx_bnum     <= bnum;
      end
    end
  end

  // saturating per-class frame counters
  always_ff @(posedge gmii_rxc or posedge reset) begin
    if (reset) begin
      cnt_good <= '0;
      cnt_crc  <= '0;
      cnt_len  <= '0;
      cnt_phy  <= '0;
    end else if (frame_end) begin
      if (frame_ok && cnt_good != '1) cnt_good <= cnt_good + 1'b1;
      if (crc_bad  && cnt_crc  != '1) cnt_crc  <= cnt_crc + 1'b1;
      if (len_bad  && cnt_len  != '1) cnt_len  <= cnt_len + 1'b1;
      if (phy_acc  && cnt_phy  != '1) cnt_phy  <= cnt_phy + 1'b1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_checker.sv
// Scoreboard bench for gmii_rx_checker: directed frames push expected status,
// a monitor pops and compares on each rx_done pulse.
module tb_gmii_rx_checker;

  localparam logic [47:0] MAC  = 48'h02_12_34_56_78_01;
  localparam logic [47:0] SRC  = 48'h02_00_00_00_00_AA;
  localparam logic [47:0] BCST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHR = 48'h02_12_34_56_78_02;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxer;
  logic        rx_done, rx_ok, rx_crc_err, rx_len_err, rx_phy_err, rx_addr_hit;
  logic [47:0] rx_dst_mac, rx_src_mac;
  logic [15:0] rx_eth_type, rx_bnum;
  logic [15:0] cnt_good, cnt_crc, cnt_len, cnt_phy;
`ifdef GMII_RX_PAYLOAD_CHECK_EN
  logic        rx_pay_err;
`endif

  always #4 clk = ~clk;

  gmii_rx_checker #(.MIN_FRAME(64), .MAX_FRAME(1522), .CNT_WIDTH(16), .PROMISC(0)) dut (
    .gmii_rxc(clk), .reset(reset), .gmii_rxd(rxd), .gmii_rxdv(rxdv), .gmii_rxer(rxer),
    .mac_addr(MAC), .rx_done(rx_done), .rx_ok(rx_ok), .rx_crc_err(rx_crc_err),
    .rx_len_err(rx_len_err), .rx_phy_err(rx_phy_err), .rx_addr_hit(rx_addr_hit),
    .rx_dst_mac(rx_dst_mac), .rx_src_mac(rx_src_mac), .rx_eth_type(rx_eth_type),
    .rx_bnum(rx_bnum),
`ifdef GMII_RX_PAYLOAD_CHECK_EN
    .rx_pay_err(rx_pay_err),
`endif
    .cnt_good(cnt_good), .cnt_crc(cnt_crc), .cnt_len(cnt_len), .cnt_phy(cnt_phy)
  );

  typedef struct {
    logic        ok, crc, len, phy, hit, pay;
    logic [15:0] bnum, etype;
    logic [47:0] dst;
    logic [15:0] cg, cc, cl, cp;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [7:0]  fr[$];
  int          total = 0;
  int          bad = 0;
  int          mg = 0, mc = 0, ml = 0, mp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // monitor: every rx_done must match the oldest expected frame
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got=1 exp=0");
      end else begin
        e = sb.pop_front();
        chk("rx_ok", rx_ok, e.ok);
        chk("rx_crc_err", rx_crc_err, e.crc);
        chk("rx_len_err", rx_len_err, e.len);
        chk("rx_phy_err", rx_phy_err, e.phy);
        chk("rx_addr_hit", rx_addr_hit, e.hit);
        chk("rx_bnum", rx_bnum, e.bnum);
        chk("rx_eth_type", rx_eth_type, e.etype);
        chk("rx_dst_mac", rx_dst_mac, e.dst);
        chk("rx_src_mac", rx_src_mac, SRC);
        chk("cnt_good", cnt_good, e.cg);
        chk("cnt_crc", cnt_crc, e.cc);
        chk("cnt_len", cnt_len, e.cl);
        chk("cnt_phy", cnt_phy, e.cp);
`ifdef GMII_RX_PAYLOAD_CHECK_EN
        chk("rx_pay_err", rx_pay_err, e.pay);
`endif
      end
    end
  end

  // build dst..FCS into fr; payload byte k = (k+1) mod 256 unless k == zero_idx
  task automatic build(input logic [47:0] dst, input int plen, input int zero_idx);
    logic [31:0] c;
    logic [7:0]  b;
    fr.delete();
    for (int i = 5; i >= 0; i--) fr.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(SRC[8*i +: 8]);
    b = 8'(plen >> 8); fr.push_back(b);
    b = 8'(plen);      fr.push_back(b);
    for (int k = 0; k < plen; k++) begin
      b = (k == zero_idx) ? 8'h00 : 8'((k + 1) % 256);
      fr.push_back(b);
    end
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < fr.size(); i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  task automatic expect_f(input logic [47:0] dst, input int plen, input bit crcbad,
                          input bit phy, input bit paybad);
    exp_t x;
    int   n;
    n       = plen + 18;
    x.crc   = crcbad;
    x.len   = (n < 64) || (n > 1522);
    x.phy   = phy;
    x.hit   = (dst == MAC) || (dst == BCST);
`ifdef GMII_RX_PAYLOAD_CHECK_EN
    x.pay   = paybad;
`else
    x.pay   = 1'b0;
`endif
    x.ok    = !x.crc && !x.len && !x.phy && x.hit && !x.pay;
    x.bnum  = 16'((n > 1523) ? 1523 : n);
    x.etype = 16'(plen);
    x.dst   = dst;
    if (x.ok)  mg++;
    if (x.crc) mc++;
    if (x.len) ml++;
    if (x.phy) mp++;
    x.cg = 16'(mg); x.cc = 16'(mc); x.cl = 16'(ml); x.cp = 16'(mp);
    sb.push_back(x);
  endtask

  task automatic drive(input logic [7:0] b, input logic er);
    rxdv = 1'b1; rxd = b; rxer = er;
    @(negedge clk);
  endtask

  // preamble + SFD + fr, then ifg idle cycles; rxer pulsed on body byte rxer_at
  task automatic send(input int ifg, input int rxer_at);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < fr.size(); i++) drive(fr[i], i == rxer_at);
    rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
    repeat (ifg) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_ok", rx_ok, 1'b0);
    chk("reset_cnt_good", cnt_good, 16'd0);
    chk("reset_bnum", rx_bnum, 16'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // good 64-byte unicast frame
    build(MAC, 46, -1); expect_f(MAC, 46, 0, 0, 0); send(12, -1);
    // bit flip in payload byte 20 after FCS computed
    build(MAC, 46, -1); fr[34] = fr[34] ^ 8'h08; expect_f(MAC, 46, 1, 0, 1); send(12, -1);
    // runt with good FCS
    build(MAC, 42, -1); expect_f(MAC, 42, 0, 0, 0); send(12, -1);
    // 1600-byte oversize frame
    build(MAC, 1582, -1); expect_f(MAC, 1582, 0, 0, 0); send(12, -1);
    // rxer one cycle mid-payload
    build(MAC, 46, -1); expect_f(MAC, 46, 0, 1, 0); send(12, 30);
    // broadcast and foreign unicast destinations
    build(BCST, 46, -1); expect_f(BCST, 46, 0, 0, 0); send(12, -1);
    build(OTHR, 46, -1); expect_f(OTHR, 46, 0, 0, 0); send(12, -1);

    // bad preamble: must be dropped silently
    drive(8'h55, 1'b0); drive(8'h55, 1'b0); drive(8'hAA, 1'b0);
    build(MAC, 46, -1);
    for (int i = 0; i < 20; i++) drive(fr[i], 1'b0);
    rxdv = 1'b0; repeat (12) @(negedge clk);

    // reset asserted mid-body aborts the frame and clears everything
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) drive(fr[i], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_done", rx_done, 1'b0);
    chk("midreset_ok", rx_ok, 1'b0);
    chk("midreset_addr_hit", rx_addr_hit, 1'b0);
    chk("midreset_cnt_good", cnt_good, 16'd0);
    chk("midreset_cnt_crc", cnt_crc, 16'd0);
    chk("midreset_cnt_len", cnt_len, 16'd0);
    chk("midreset_cnt_phy", cnt_phy, 16'd0);
    chk("midreset_dst", rx_dst_mac, 48'h0);
    rxdv = 1'b0;
    mg = 0; mc = 0; ml = 0; mp = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    build(MAC, 46, -1); expect_f(MAC, 46, 0, 0, 0); send(12, -1);
    // back-to-back good frames with a one-cycle gap
    build(MAC, 46, -1); expect_f(MAC, 46, 0, 0, 0); send(1, -1);
    expect_f(MAC, 46, 0, 0, 0); send(12, -1);

`ifdef GMII_RX_PAYLOAD_CHECK_EN
    build(MAC, 46, 5); expect_f(MAC, 46, 0, 0, 1); send(12, -1);
    build(MAC, 46, -1); expect_f(MAC, 46, 0, 0, 0); send(12, -1);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL missing_done got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
